// File: rtl/arcsine_pkg.sv
// Shared types, widths and Q8.8 constants for the arcsine block.
package arcsine_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned FRAC_W = 8;
    localparam int unsigned COEF_W = 8;
    localparam int unsigned K_W    = 3;
    localparam int unsigned PROD_W = 32;
    localparam int unsigned K_LAST = 7;

    localparam logic [DATA_W-1:0] ONE  = 16'h0100;
    localparam logic [DATA_W-1:0] PI_2 = 16'h0192;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_LOAD,
        S_MUL1,
        S_MUL2,
        S_ADD,
        S_CHECK
    } state_e;

    // Q8.8 multiply: full product, keep bits [23:8], truncating.
    function automatic logic [DATA_W-1:0] q_mul(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
        return DATA_W'((PROD_W'(a) * PROD_W'(b)) >> FRAC_W);
    endfunction

endpackage

// File: rtl/arcsine_if.sv
// Request/result bundle between a requester and the arcsine unit.
interface arcsine_if;
    import arcsine_pkg::*;

    logic              start;
    logic [DATA_W-1:0] x1;
    logic [COEF_W-1:0] y;
    logic [DATA_W-1:0] z;
    logic              ready;

    modport master (output start, x1, y, input z, ready);
    modport slave  (input start, x1, y, output z, ready);

endinterface

// File: rtl/arcsine_coef_rom.sv
// Series coefficients (2k-1)^2/((2k)(2k+1)) in Q0.8, indexed by iteration k.
module arcsine_coef_rom
    import arcsine_pkg::*;
(
    input  logic [K_W-1:0]    k_i,
    output logic [COEF_W-1:0] coef_c
);

    always_comb begin
        coef_c = '0;
        unique case (k_i)
            3'd1:    coef_c = 8'h2B;
            3'd2:    coef_c = 8'h73;
            3'd3:    coef_c = 8'h98;
            3'd4:    coef_c = 8'hAE;
            3'd5:    coef_c = 8'hBD;
            3'd6:    coef_c = 8'hC7;
            3'd7:    coef_c = 8'hCE;
            default: coef_c = '0;
        endcase
    end

endmodule

// File: rtl/arcsine.sv
// Taylor-series arcsine of a Q8.8 operand in [0,1]; one series term per four cycles.
module arcsine
    import arcsine_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    arcsine_if.slave bus
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] x2_q, term_q, z_q;
    logic [COEF_W-1:0] yreg_q;
    logic [K_W-1:0]    k_q;
    logic              ready_q;

    logic [COEF_W-1:0] coef;
    logic [DATA_W-1:0] x2_prod, mul1_prod, mul2_prod;
    logic              sat_c, stop_c;
    logic              load_c, mul1_c, mul2_c, add_c, next_c;

    arcsine_coef_rom u_coef_rom (
        .k_i    (k_q),
        .coef_c (coef)
    );

    assign x2_prod   = q_mul(bus.x1, bus.x1);
    assign mul1_prod = q_mul(term_q, x2_q);
    assign mul2_prod = q_mul(term_q, DATA_W'(coef));

    assign sat_c  = (bus.x1 >= ONE);
    // Stop once the newest term falls below threshold, or after the last coefficient.
    assign stop_c = ((term_q[DATA_W-1:FRAC_W] == '0) && (term_q[FRAC_W-1:0] < yreg_q))
                  || (k_q == K_W'(K_LAST));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (bus.start)  state_d = S_START;
            S_START: if (!bus.start) state_d = S_LOAD;
            S_LOAD:  state_d = sat_c ? S_IDLE : S_MUL1;
            S_MUL1:  state_d = S_MUL2;
            S_MUL2:  state_d = S_ADD;
            S_ADD:   state_d = S_CHECK;
            S_CHECK: state_d = stop_c ? S_IDLE : S_MUL1;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        load_c = 1'b0;
        mul1_c = 1'b0;
        mul2_c = 1'b0;
        add_c  = 1'b0;
        next_c = 1'b0;
        unique case (state_q)
            S_LOAD:  load_c = 1'b1;
            S_MUL1:  mul1_c = 1'b1;
            S_MUL2:  mul2_c = 1'b1;
            S_ADD:   add_c  = 1'b1;
            S_CHECK: next_c = !stop_c;
            default: ;
        endcase
    end

    // term_q also serves as the latched operand x: it holds x1 until the first MUL1.
    always_ff @(posedge clk) begin
        if (rst) begin
            x2_q    <= '0;
            term_q  <= '0;
            z_q     <= '0;
            yreg_q  <= '0;
            k_q     <= '0;
            ready_q <= 1'b1;
        end else begin
            ready_q <= (state_d == S_IDLE);
            if (load_c) begin
                x2_q   <= x2_prod;
                term_q <= bus.x1;
                yreg_q <= bus.y;
                k_q    <= K_W'(1);
                z_q    <= sat_c ? PI_2 : bus.x1;
            end else if (mul1_c) begin
                term_q <= mul1_prod;
            end else if (mul2_c) begin
                term_q <= mul2_prod;
            end else if (add_c) begin
                z_q <= z_q + term_q;
            end else if (next_c) begin
                k_q <= k_q + K_W'(1);
            end
        end
    end

    assign bus.z     = z_q;
    assign bus.ready = ready_q;

endmodule

// File: tb/tb_arcsine.sv
// Directed bench for arcsine: series model plus per-cycle ready/result monitor.
module tb_arcsine;

    logic clk;
    logic rst;

    arcsine_if bus_if ();

    arcsine dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int          checks   = 0;
    int          failures = 0;
    bit          mon_en   = 1'b0;
    logic        exp_ready;
    logic [15:0] exp_z;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
        end
    endtask

    // Reference: coefficients derived from the closed form, rounded to Q0.8.
    function automatic int coef_of(input int k);
        int num, den;
        num = (2 * k - 1) * (2 * k - 1) * 512;
        den = 2 * (2 * k) * (2 * k + 1);
        return (num + den / 2 * 2 / 2) / den;
    endfunction

    function automatic void model(input int x1v, input int yv, output int zo, output int lato);
        int x2, term, it;
        if (x1v >= 256) begin
            zo   = 'h192;
            lato = 1;
            return;
        end
        x2   = ((x1v * x1v) >> 8) & 'hFFFF;
        term = x1v;
        zo   = x1v;
        it   = 0;
        for (int k = 1; k <= 7; k++) begin
            term = ((term * x2) >> 8) & 'hFFFF;
            term = ((term * ((2 * (2 * k - 1) * (2 * k - 1) * 256 + 2 * k * (2 * k + 1))
                    / (2 * (2 * k) * (2 * k + 1)))) >> 8) & 'hFFFF;
            zo   = (zo + term) & 'hFFFF;
            it++;
            if (term < 256 && term < yv) break;
        end
        lato = 1 + 4 * it;
    endfunction

    // Per-cycle monitor: ready always, z whenever the unit should be idle.
    always begin
        @(posedge clk);
        #1;
        if (mon_en) begin
            check("ready", int'(bus_if.ready), int'(exp_ready));
            if (exp_ready) check("z_idle", int'(bus_if.z), int'(exp_z));
        end
    end

    task automatic run(input logic [15:0] x1v, input logic [7:0] yv, input int hold,
                       input bit disturb, input int lit_z, input int lit_lat);
        int ez, elat, cnt;
        bit done;
        model(int'(x1v), int'(yv), ez, elat);
        if (lit_z >= 0) begin
            check("model_z", ez, lit_z);
            check("model_lat", elat, lit_lat);
        end
        bus_if.x1    = x1v;
        bus_if.y     = yv;
        bus_if.start = 1'b1;
        exp_ready    = 1'b0;
        repeat (hold) begin
            @(posedge clk);
            #2;
        end
        bus_if.start = 1'b0;
        @(posedge clk);
        #2;
        cnt  = 0;
        done = 1'b0;
        while (!done && cnt < 40) begin
            if (cnt + 1 == elat) begin
                exp_ready = 1'b1;
                exp_z     = 16'(ez);
            end
            if (disturb && cnt == 2) begin
                bus_if.start = 1'b1;
                bus_if.x1    = 16'h0040;
                bus_if.y     = 8'hFF;
            end
            if (disturb && cnt == 4) begin
                bus_if.start = 1'b0;
                bus_if.x1    = 16'h00C0;
            end
            @(posedge clk);
            #2;
            cnt++;
            done = bus_if.ready;
        end
        check("latency", cnt, elat);
        check("z_result", int'(bus_if.z), ez);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst          = 1'b1;
        bus_if.start = 1'b0;
        bus_if.x1    = '0;
        bus_if.y     = '0;
        exp_ready    = 1'b1;
        exp_z        = '0;
        @(posedge clk);
        #2;
        check("rst_z", int'(bus_if.z), 0);
        check("rst_ready", int'(bus_if.ready), 1);
        mon_en = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #2;
        end

        run(16'h0080, 8'h01, 5, 1'b0, 'h85, 9);
        run(16'h0000, 8'h00, 1, 1'b0, 'h0, 29);
        run(16'h0100, 8'h20, 2, 1'b0, 'h192, 1);
        run(16'h0180, 8'h01, 1, 1'b0, 'h192, 1);
        run(16'h00C0, 8'h04, 1, 1'b0, 'hD7, 13);
        run(16'h00FF, 8'h00, 1, 1'b0, -1, 0);
        run(16'h0040, 8'h02, 3, 1'b0, -1, 0);
        run(16'h0080, 8'h01, 1, 1'b1, 'h85, 9);

        // Abort during MUL2 of the first iteration.
        bus_if.x1    = 16'h0080;
        bus_if.y     = 8'h01;
        bus_if.start = 1'b1;
        exp_ready    = 1'b0;
        @(posedge clk);
        #2;
        bus_if.start = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #2;
        end
        rst       = 1'b1;
        exp_ready = 1'b1;
        exp_z     = '0;
        @(posedge clk);
        #2;
        rst = 1'b0;
        check("abort_z", int'(bus_if.z), 0);
        check("abort_ready", int'(bus_if.ready), 1);
        run(16'h0080, 8'h01, 1, 1'b0, 'h85, 9);

        // Reset wins over a simultaneous start request.
        rst          = 1'b1;
        bus_if.start = 1'b1;
        exp_ready    = 1'b1;
        exp_z        = '0;
        @(posedge clk);
        #2;
        rst          = 1'b0;
        bus_if.start = 1'b0;
        check("prio_ready", int'(bus_if.ready), 1);
        check("prio_z", int'(bus_if.z), 0);
        repeat (2) begin
            @(posedge clk);
            #2;
        end

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
